// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel arbiter: resolves hardware/software requests into one locked
// grant, drives VALID_DREQ/DACK during service and maintains the rotation pointer.
module dma_priority_arbiter #(
    parameter int unsigned NCH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NCH-1:0]           DREQ,
    input  logic [NCH-1:0]           maskReg,
    input  logic [NCH-1:0]           reqReg,
    input  logic                     ctrlDisable,
    input  logic                     rotPrio,
    input  logic                     dreqActLow,
    input  logic                     dackActHigh,
    input  logic                     hrq,
    input  logic                     HLDA,
    input  logic                     validDACK,
    input  logic                     tcDone,
    output logic [NCH-1:0]           VALID_DREQ,
    output logic [NCH-1:0]           DACK,
    output logic [$clog2(NCH)-1:0]   grantChan,
    output logic [NCH-1:0]           clrReq,
    output logic [$clog2(NCH)-1:0]   prioPtr
);
    localparam int unsigned PW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, GRANT, SERVICE, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [NCH-1:0]  eff;
    logic [NCH-1:0]  valid_nxt, dack_nxt, clr_nxt;
    logic [PW-1:0]   grant_nxt, ptr_nxt, winner, idx;
    logic            found, hrq_q, exit_svc;

    assign eff      = ((DREQ ^ {NCH{dreqActLow}}) & ~maskReg) | reqReg;
    assign exit_svc = tcDone | (hrq_q & ~hrq);

    // Scan from the pointer upward; the PW-bit add wraps the index modulo NCH.
    always_comb begin
        winner = prioPtr;
        found  = 1'b0;
        idx    = prioPtr;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = prioPtr + PW'(k);
            if (!found && eff[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = VALID_DREQ;
        grant_nxt = grantChan;
        clr_nxt   = '0;
        ptr_nxt   = rotPrio ? prioPtr : '0;
        dack_nxt  = {NCH{~dackActHigh}};
        case (state)
            IDLE: begin
                if (!ctrlDisable && found) begin
                    state_nxt         = GRANT;
                    grant_nxt         = winner;
                    valid_nxt         = '0;
                    valid_nxt[winner] = 1'b1;
                end
            end
            GRANT: begin
                if (hrq) begin
                    state_nxt = SERVICE;
                end else if (!eff[grantChan]) begin
                    state_nxt = IDLE;
                    valid_nxt = '0;
                end
            end
            SERVICE: begin
                // Release actions are registered on the exit edge so they are visible in RELEASE.
                if (exit_svc) begin
                    state_nxt = RELEASE;
                    valid_nxt = '0;
                    if (tcDone) clr_nxt[grantChan] = 1'b1;
                    if (rotPrio) ptr_nxt = grantChan + PW'(1);
                end else if (HLDA && validDACK) begin
                    dack_nxt[grantChan] = dackActHigh;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            VALID_DREQ <= '0;
            DACK       <= '1;
            grantChan  <= '0;
            clrReq     <= '0;
            prioPtr    <= '0;
            hrq_q      <= 1'b0;
        end else begin
            VALID_DREQ <= valid_nxt;
            DACK       <= dack_nxt;
            grantChan  <= grant_nxt;
            clrReq     <= clr_nxt;
            prioPtr    <= ptr_nxt;
            hrq_q      <= hrq;
        end
    end
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: a cycle model checked every clock plus
// hand-computed expectations at key points of each scenario.
module tb_dma_priority_arbiter;
    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ, maskReg, reqReg;
    logic       ctrlDisable, rotPrio, dreqActLow, dackActHigh;
    logic       hrq, HLDA, validDACK, tcDone;
    logic [3:0] VALID_DREQ, DACK, clrReq;
    logic [1:0] grantChan, prioPtr;

    int vectors = 0;
    int fails   = 0;

    dma_priority_arbiter #(.NCH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg), .reqReg(reqReg),
        .ctrlDisable(ctrlDisable), .rotPrio(rotPrio), .dreqActLow(dreqActLow),
        .dackActHigh(dackActHigh), .hrq(hrq), .HLDA(HLDA), .validDACK(validDACK),
        .tcDone(tcDone), .VALID_DREQ(VALID_DREQ), .DACK(DACK), .grantChan(grantChan),
        .clrReq(clrReq), .prioPtr(prioPtr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 granted awaiting hrq, 2 serving, 3 releasing.
    int         m_phase, m_ch, m_ptr;
    bit         m_prev;
    logic [3:0] m_valid, m_dack, m_clr;

    task automatic model_step();
        logic [3:0] e;
        int pick, nptr;
        if (RESET) begin
            m_phase = 0; m_ch = 0; m_ptr = 0; m_prev = 0;
            m_valid = 4'h0; m_dack = 4'hF; m_clr = 4'h0;
            return;
        end
        e      = ((DREQ ^ {4{dreqActLow}}) & ~maskReg) | reqReg;
        m_clr  = 4'h0;
        m_dack = dackActHigh ? 4'h0 : 4'hF;
        nptr   = rotPrio ? m_ptr : 0;
        case (m_phase)
            0: if (!ctrlDisable && e != 4'h0) begin
                pick = -1;
                for (int k = 0; k < 4; k++)
                    if (pick < 0 && e[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
                m_ch    = pick;
                m_valid = 4'h1 << pick;
                m_phase = 1;
            end
            1: if (hrq) m_phase = 2;
               else if (!e[m_ch]) begin m_phase = 0; m_valid = 4'h0; end
            2: if (tcDone || (m_prev && !hrq)) begin
                m_phase = 3;
                m_valid = 4'h0;
                if (tcDone) m_clr = 4'h1 << m_ch;
                if (rotPrio) nptr = (m_ch + 1) % 4;
            end else if (HLDA && validDACK) begin
                m_dack[m_ch] = dackActHigh;
            end
            default: m_phase = 0;
        endcase
        m_ptr  = nptr;
        m_prev = hrq;
    endtask

    initial forever begin
        @(posedge CLK or posedge RESET);
        model_step();
    end

    always @(posedge CLK) begin
        #1;
        if (!RESET) begin
            check("model_valid_dreq", VALID_DREQ, m_valid);
            check("model_dack", DACK, m_dack);
            check("model_grant_chan", grantChan, m_ch);
            check("model_clr_req", clrReq, m_clr);
            check("model_prio_ptr", prioPtr, m_ptr);
        end
    end

    task automatic wait_grant();
        bit ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (VALID_DREQ != 4'h0) begin ok = 1; break; end
        end
        check("grant_timeout", ok, 1);
    endtask

    // mode 0: hrq falls, 1: tcDone, 2: both in the same cycle
    task automatic serve(input int mode, input logic [3:0] nd);
        @(negedge CLK) hrq = 1;
        @(negedge CLK) begin HLDA = 1; validDACK = 1; end
        @(negedge CLK);
        tcDone = (mode != 0);
        if (mode != 1) hrq = 0;
        DREQ = nd;
        @(negedge CLK);
        tcDone = 0; hrq = 0; HLDA = 0; validDACK = 0;
    endtask

    initial begin
        RESET = 1; DREQ = 0; maskReg = 0; reqReg = 0; ctrlDisable = 0; rotPrio = 0;
        dreqActLow = 0; dackActHigh = 0; hrq = 0; HLDA = 0; validDACK = 0; tcDone = 0;
        repeat (2) @(negedge CLK);
        check("rst_valid", VALID_DREQ, 4'h0);
        check("rst_dack", DACK, 4'hF);
        check("rst_ptr", prioPtr, 0);
        RESET = 0;

        // Fixed priority contention and DACK polarity on ch1
        @(negedge CLK) DREQ = 4'b1010;
        wait_grant();
        check("fixed_first", VALID_DREQ, 4'b0010);
        @(negedge CLK) hrq = 1;
        @(negedge CLK) begin HLDA = 1; validDACK = 1; end
        @(negedge CLK) check("dack_low", DACK, 4'b1101);
        dackActHigh = 1;
        @(negedge CLK) check("dack_high", DACK, 4'b0010);
        validDACK = 0;
        @(negedge CLK) check("dack_nowin", DACK, 4'b0000);
        dackActHigh = 0; tcDone = 1; DREQ = 4'b1000;
        @(negedge CLK);
        check("fixed_clr", clrReq, 4'b0010);
        check("fixed_ptr", prioPtr, 0);
        tcDone = 0; hrq = 0; HLDA = 0;
        wait_grant();
        check("fixed_second", VALID_DREQ, 4'b1000);
        check("fixed_ptr2", prioPtr, 0);
        serve(1, 4'b0000);

        // Rotating priority, all channels requesting
        @(negedge CLK) begin rotPrio = 1; DREQ = 4'b1111; end
        for (int n = 0; n < 5; n++) begin
            wait_grant();
            check("rot_grant", VALID_DREQ, 4'h1 << (n % 4));
            serve(1, (n == 4) ? 4'b0000 : 4'b1111);
            check("rot_ptr", prioPtr, (n + 1) % 4);
            check("rot_clr", clrReq, 4'h1 << (n % 4));
        end
        @(negedge CLK) rotPrio = 0;
        @(negedge CLK) check("rot_off_ptr", prioPtr, 0);

        // Mask everything, software request on ch2
        @(negedge CLK) begin maskReg = 4'b1111; DREQ = 4'b1111; reqReg = 4'b0100; end
        wait_grant();
        check("sw_grant", VALID_DREQ, 4'b0100);
        serve(1, 4'b1111);
        check("sw_clr", clrReq, 4'b0100);
        reqReg = 0;
        @(negedge CLK) check("sw_clr_end", clrReq, 4'b0000);
        maskReg = 0; DREQ = 0;

        // Active-low DREQ, simultaneous tcDone and hrq fall
        @(negedge CLK) begin dreqActLow = 1; DREQ = 4'b1111; end
        repeat (3) @(negedge CLK);
        check("actlow_idle", VALID_DREQ, 4'b0000);
        DREQ = 4'b1011;
        wait_grant();
        check("actlow_grant", VALID_DREQ, 4'b0100);
        serve(2, 4'b1111);
        check("both_clr", clrReq, 4'b0100);
        dreqActLow = 0; DREQ = 0;

        // hrq falling alone ends service without clrReq
        @(negedge CLK) DREQ = 4'b0010;
        wait_grant();
        serve(0, 4'b0000);
        check("hrqfall_clr", clrReq, 4'b0000);
        check("hrqfall_valid", VALID_DREQ, 4'b0000);

        // Withdrawal before hrq
        repeat (2) @(negedge CLK);
        DREQ = 4'b0001;
        @(negedge CLK) begin DREQ = 0; check("wd_grant", VALID_DREQ, 4'b0001); end
        @(negedge CLK) check("wd_drop", VALID_DREQ, 4'b0000);

        // Controller disabled
        @(negedge CLK) begin ctrlDisable = 1; DREQ = 4'b1111; end
        repeat (8) @(negedge CLK);
        check("disable_none", VALID_DREQ, 4'b0000);
        ctrlDisable = 0; DREQ = 0;

        // Reset in mid-service after the pointer has moved
        @(negedge CLK) begin rotPrio = 1; DREQ = 4'b0100; end
        wait_grant();
        serve(1, 4'b0000);
        check("pre_rst_ptr", prioPtr, 3);
        DREQ = 4'b1001;
        wait_grant();
        check("pre_rst_grant", VALID_DREQ, 4'b1000);
        @(negedge CLK) hrq = 1;
        @(negedge CLK) begin HLDA = 1; validDACK = 1; end
        @(negedge CLK) check("pre_rst_dack", DACK, 4'b0111);
        #2 RESET = 1;
        #1;
        check("arst_valid", VALID_DREQ, 4'h0);
        check("arst_dack", DACK, 4'hF);
        check("arst_grant", grantChan, 0);
        check("arst_clr", clrReq, 4'h0);
        check("arst_ptr", prioPtr, 0);
        hrq = 0; HLDA = 0; validDACK = 0;
        @(negedge CLK) RESET = 0;
        wait_grant();
        check("post_rst_grant", VALID_DREQ, 4'b0001);
        check("post_rst_ptr", prioPtr, 0);
        DREQ = 0;
        repeat (4) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
